// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: request bundle, per-port FSM states
// and the reset PC that doubles as the default memory base address.
package mem_responder_pkg;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  function automatic logic req_valid(input mem_req_t r);
    return (r.rmask | r.wmask) != 4'h0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side imem/dmem request bus; the CPU drives it as master, the responder as slave.
interface mem_responder_if;

  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/mem_resp_port.sv
// One responder port: captures a request, counts out the latency, pulses resp,
// and flags requests that arrive while busy unless they repeat the captured one.
module mem_resp_port
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_req_t req,
  output mem_req_t cap,
  output logic     resp,
  output logic     conflict
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  mem_req_t    cap_q, cap_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    conflict = 1'b0;
    case (state_q)
      WAIT: begin
        cnt_d    = cnt_q - 4'd1;
        conflict = req_valid(req) && (req != cap_q);
        if (cnt_d == 4'd0) begin
          state_d = RESP;
        end
      end
      default: begin
        // RESP behaves like IDLE for acceptance so back-to-back requests see no gap
        state_d = IDLE;
        if (req_valid(req)) begin
          cap_d   = req;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  assign cap  = cap_q;
  assign resp = (state_q == RESP);

endmodule

// File: rtl/mem_responder.sv
// Memory responder backing the CPU imem and dmem ports with one shared word array,
// fixed per-port latency and a sticky error flag for protocol and address faults.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = RESET_PC,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned I_LATENCY  = 2,
  parameter int unsigned D_LATENCY  = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus,
  output logic            err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  mem_req_t i_req, d_req, i_cap, d_cap;
  logic     i_resp, d_resp, i_conflict, d_conflict;
  logic     err_q, err_d;

  assign i_req = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign d_req = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                   wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

  mem_resp_port #(.LATENCY(I_LATENCY)) u_imem_port (
    .clk      (clk),
    .rst      (rst),
    .req      (i_req),
    .cap      (i_cap),
    .resp     (i_resp),
    .conflict (i_conflict)
  );

  mem_resp_port #(.LATENCY(D_LATENCY)) u_dmem_port (
    .clk      (clk),
    .rst      (rst),
    .req      (d_req),
    .cap      (d_cap),
    .resp     (d_resp),
    .conflict (d_conflict)
  );

  // Word offset from the base; upper bits nonzero means the index is past the array
  logic [29:0]           i_off, d_off;
  logic                  i_ok, d_ok, d_rw_both;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;

  assign i_off     = 30'((i_cap.addr - BASE_ADDR) >> 2);
  assign d_off     = 30'((d_cap.addr - BASE_ADDR) >> 2);
  assign i_ok      = (i_off[29:DEPTH_LOG2] == '0) && (i_cap.addr[1:0] == 2'b00);
  assign d_ok      = (d_off[29:DEPTH_LOG2] == '0) && (d_cap.addr[1:0] == 2'b00);
  assign i_idx     = i_off[DEPTH_LOG2-1:0];
  assign d_idx     = d_off[DEPTH_LOG2-1:0];
  assign d_rw_both = (d_cap.rmask != 4'h0) && (d_cap.wmask != 4'h0);

  logic unused_imem_fields;
  assign unused_imem_fields = ^{i_cap.wmask, i_cap.wdata};

  always_comb begin
    bus.imem_rdata = 32'h0;
    bus.dmem_rdata = 32'h0;
    if (i_resp && i_ok) begin
      bus.imem_rdata = mem_q[i_idx];
    end
    if (d_resp && d_ok && (d_cap.wmask == 4'h0)) begin
      bus.dmem_rdata = mem_q[d_idx];
    end
  end

  assign bus.imem_resp = i_resp;
  assign bus.dmem_resp = d_resp;

  // Writes land on the edge closing RESP, so same-cycle reads still see the old word
  always_ff @(posedge clk) begin
    if (d_resp && d_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (d_cap.wmask[b]) begin
          mem_q[d_idx][8*b +: 8] <= d_cap.wdata[8*b +: 8];
        end
      end
    end
  end

  assign err_d = err_q | i_conflict | d_conflict
               | (i_resp && !i_ok)
               | (d_resp && (!d_ok || d_rw_both));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// single transactions scored against a word-array model of the memory map.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h1eceb000;
  localparam int I_LAT    = 2;
  localparam int D_LAT    = 3;
  localparam int MAX_WAIT = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  int check_count = 0;
  int pass_count  = 0;

  logic [31:0] model_mem   [1024];
  bit          model_known [1024];
  logic        err_exp;

  mem_responder_if bus ();

  mem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (10),
    .I_LATENCY  (I_LAT),
    .D_LATENCY  (D_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (!bus.imem_resp) checkOutput("imem_rdata_idle", bus.imem_rdata, 32'h0);
    if (!bus.dmem_resp) checkOutput("dmem_rdata_idle", bus.dmem_rdata, 32'h0);
  endtask

  task automatic dropRequests();
    bus.imem_addr  = 32'h0;
    bus.imem_rmask = 4'h0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    bus.dmem_wdata = 32'h0;
  endtask

  function automatic bit inRange(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd4096) && (a[1:0] == 2'b00);
  endfunction

  function automatic int wordIndex(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off[9:0]);
  endfunction

  task automatic resetDut();
    rst = 1'b0;
    dropRequests();
    #1;
    checkOutput("reset_imem_resp", 32'(bus.imem_resp), 32'h0);
    checkOutput("reset_dmem_resp", 32'(bus.dmem_resp), 32'h0);
    tick();
    checkOutput("reset_imem_rdata", bus.imem_rdata, 32'h0);
    checkOutput("reset_dmem_rdata", bus.dmem_rdata, 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    rst = 1'b1;
    err_exp = 1'b0;
    tick();
    checkOutput("post_reset_err", 32'(err), 32'h0);
  endtask

  // One isolated transaction on either port, scored against the model
  task automatic applyStimulus(input bit is_data, input logic [31:0] addr,
                               input logic [3:0] rmask, input logic [3:0] wmask,
                               input logic [31:0] wdata, input string tag);
    int          lat;
    int          idx;
    bit          ok;
    bit          data_known;
    logic [31:0] exp_data;
    logic [31:0] observed;
    ok  = inRange(addr);
    idx = wordIndex(addr);
    if (is_data) begin
      bus.dmem_addr  = addr;
      bus.dmem_rmask = rmask;
      bus.dmem_wmask = wmask;
      bus.dmem_wdata = wdata;
    end else begin
      bus.imem_addr  = addr;
      bus.imem_rmask = rmask;
    end
    tick();
    dropRequests();
    lat = 1;
    while (!(is_data ? bus.dmem_resp : bus.imem_resp) && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(is_data ? D_LAT : I_LAT));
    if (!ok || wmask != 4'h0) begin
      data_known = 1'b1;
      exp_data   = 32'h0;
    end else begin
      data_known = model_known[idx];
      exp_data   = model_mem[idx];
    end
    observed = is_data ? bus.dmem_rdata : bus.imem_rdata;
    if (data_known) checkOutput({tag, "_rdata"}, observed, exp_data);
    if (ok && wmask != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      if (wmask == 4'hf) model_known[idx] = 1'b1;
    end
    if (!ok || (rmask != 4'h0 && wmask != 4'h0)) err_exp = 1'b1;
    tick();
    checkOutput({tag, "_resp_pulse"}, 32'(is_data ? bus.dmem_resp : bus.imem_resp), 32'h0);
    checkOutput({tag, "_err"}, 32'(err), 32'(err_exp));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] old_word;
    logic [31:0] a;
    logic [3:0]  rm, wm;
    bit          is_data;
    int          sel, kind;

    err_exp = 1'b0;
    for (int i = 0; i < 1024; i++) model_known[i] = 1'b0;
    dropRequests();
    resetDut();

    applyStimulus(1, BASE, 4'h0, 4'hf, 32'hdeadbeef, "init0");
    applyStimulus(1, BASE + 32'd4, 4'h0, 4'hf, 32'h0, "init1");
    for (int i = 2; i < 32; i++)
      applyStimulus(1, BASE + 32'(4 * i), 4'h0, 4'hf, $urandom, "init");

    applyStimulus(0, BASE, 4'hf, 4'h0, 32'h0, "ifetch0");
    applyStimulus(1, BASE + 32'd4, 4'h0, 4'b0101, 32'h11223344, "bytestore");
    applyStimulus(1, BASE + 32'd4, 4'hf, 4'h0, 32'h0, "byteload");

    // Back-to-back imem fetches, each issued in the previous resp cycle
    bus.imem_addr  = BASE;
    bus.imem_rmask = 4'hf;
    tick();
    dropRequests();
    for (int i = 0; i < 3; i++) begin
      checkOutput("b2b_gap", 32'(bus.imem_resp), 32'h0);
      tick();
      checkOutput("b2b_resp", 32'(bus.imem_resp), 32'h1);
      checkOutput("b2b_rdata", bus.imem_rdata, model_mem[i]);
      if (i < 2) begin
        bus.imem_addr  = BASE + 32'(4 * (i + 1));
        bus.imem_rmask = 4'hf;
      end
      tick();
      dropRequests();
    end
    checkOutput("b2b_err", 32'(err), 32'h0);

    // Same-word collision: both ports reach RESP in the same cycle
    old_word       = model_mem[4];
    bus.dmem_addr  = BASE + 32'h10;
    bus.dmem_wmask = 4'hf;
    bus.dmem_wdata = 32'hcafef00d;
    tick();
    dropRequests();
    bus.imem_addr  = BASE + 32'h10;
    bus.imem_rmask = 4'hf;
    tick();
    dropRequests();
    tick();
    checkOutput("coll_dmem_resp", 32'(bus.dmem_resp), 32'h1);
    checkOutput("coll_imem_resp", 32'(bus.imem_resp), 32'h1);
    checkOutput("coll_imem_old", bus.imem_rdata, old_word);
    model_mem[4] = 32'hcafef00d;
    tick();
    applyStimulus(0, BASE + 32'h10, 4'hf, 4'h0, 32'h0, "coll_reread");

    // Holding the same request through WAIT is legal
    bus.dmem_addr  = BASE + 32'h14;
    bus.dmem_rmask = 4'hf;
    tick();
    tick();
    dropRequests();
    tick();
    checkOutput("hold_resp", 32'(bus.dmem_resp), 32'h1);
    checkOutput("hold_rdata", bus.dmem_rdata, model_mem[5]);
    tick();
    checkOutput("hold_err", 32'(err), 32'h0);

    // A different request during WAIT is ignored and flagged
    bus.dmem_addr  = BASE + 32'h18;
    bus.dmem_rmask = 4'hf;
    tick();
    bus.dmem_addr  = BASE + 32'h1c;
    tick();
    dropRequests();
    tick();
    checkOutput("busy_resp", 32'(bus.dmem_resp), 32'h1);
    checkOutput("busy_rdata", bus.dmem_rdata, model_mem[6]);
    tick();
    err_exp = 1'b1;
    checkOutput("busy_err", 32'(err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("busy_no_extra_resp", 32'(bus.dmem_resp), 32'h0);
      tick();
    end

    resetDut();
    applyStimulus(1, BASE + 32'h2, 4'hf, 4'h0, 32'h0, "misaligned");
    applyStimulus(1, 32'h1ecec000, 4'hf, 4'h0, 32'h0, "out_of_range");
    resetDut();
    applyStimulus(1, BASE + 32'hc, 4'hf, 4'hf, 32'h5a5aa5a5, "rw_both");
    applyStimulus(0, BASE + 32'hc, 4'hf, 4'h0, 32'h0, "rw_both_readback");
    resetDut();

    // Reset during WAIT abandons the write
    bus.dmem_addr  = BASE + 32'h20;
    bus.dmem_wmask = 4'hf;
    bus.dmem_wdata = 32'hffffffff;
    tick();
    dropRequests();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midreset_resp", 32'(bus.dmem_resp), 32'h0);
    end
    rst     = 1'b1;
    err_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("midreset_no_resp", 32'(bus.dmem_resp), 32'h0);
    end
    applyStimulus(1, BASE + 32'h20, 4'hf, 4'h0, 32'h0, "midreset_word");

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, 31));
      else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
      else               a = BASE - 32'(4 * $urandom_range(1, 64));
      is_data = 1'($urandom_range(0, 1));
      rm = 4'h0;
      wm = 4'h0;
      if (is_data) begin
        kind = int'($urandom_range(0, 5));
        if (kind < 2)      rm = 4'($urandom_range(1, 15));
        else if (kind < 5) wm = 4'($urandom_range(1, 15));
        else begin
          rm = 4'($urandom_range(1, 15));
          wm = 4'($urandom_range(1, 15));
        end
      end else begin
        rm = 4'($urandom_range(1, 15));
      end
      applyStimulus(is_data, a, rm, wm, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
